// File: rtl/lifo_share_pkg.sv
// lifo_share_pkg: shared types and constants for the shared-LIFO controller.
//   state_t : controller FSM states (IDLE / XFER / RESP)
//   OP_PUSH / OP_POP : encoding of the per-requester op bit
package lifo_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/lifo_share_ctrl_if.sv
// lifo_share_if: requester-side bus of the shared LIFO controller.
//   req/op/wdata        : requester -> controller (request, 1=push/0=pop, push data slices)
//   gnt/rvalid/rdata/rid: controller -> requester (grant pulse, pop response)
//   count/full/empty/err: controller status
// Modports: master (requesters), slave (controller).
interface lifo_share_if #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         op;
  logic [NREQ*WIDTH-1:0]   wdata;
  logic [NREQ-1:0]         gnt;
  logic                    rvalid;
  logic [WIDTH-1:0]        rdata;
  logic [$clog2(NREQ)-1:0] rid;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
  logic                    err;

  modport master (
    output req, op, wdata,
    input  gnt, rvalid, rdata, rid, count, full, empty, err
  );

  modport slave (
    input  req, op, wdata,
    output gnt, rvalid, rdata, rid, count, full, empty, err
  );
endinterface

// File: rtl/lifo_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   in  NREQ          : pending requests
//   ptr   in  $clog2(NREQ)  : last winner; search begins at ptr+1 (mod NREQ)
//   grant out NREQ          : one-hot winner (zero when no request)
//   idx   out $clog2(NREQ)  : winner index
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);

  logic found;
  int   j;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && ((req >> j) & NREQ'(1)) != '0) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    grant = found ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/lifo_share_ctrl.sv
// lifo_share_ctrl: LIFO shared by NREQ requesters through a round-robin arbiter.
//   clk      in : rising-edge clock
//   reset_n  in : asynchronous active-low reset
//   bus      slave modport of lifo_share_if (req/op/wdata in; gnt/rvalid/rdata/rid/
//            count/full/empty/err out)
// One transaction at a time: IDLE picks a winner, XFER grants and executes,
// RESP returns pop data. Illegal operations (push on full, pop on empty) are
// granted, leave count untouched and raise err.
// Build option: define LIFO_ERR_STICKY_EN to make err sticky until reset.
module lifo_share_ctrl
  import lifo_share_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  lifo_share_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr;       // last arbitration winner
  logic [IW-1:0]    win;       // winner of the transaction in flight (drives rid)
  logic             win_op;
  logic [WIDTH-1:0] win_data;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [NREQ-1:0]  arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             full_c, empty_c, op_err, err_pulse, push_ok;
  logic [CW-1:0]    top_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign top_idx = count - CW'(1);
  assign op_err  = (win_op == OP_PUSH) ? full_c : empty_c;
  assign push_ok = (state == XFER) && (win_op == OP_PUSH) && !full_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|bus.req) state_nxt = XFER;
      XFER:    state_nxt = (win_op == OP_PUSH) ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner capture, occupancy and pop data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= IW'(NREQ - 1);  // first search then starts at requester 0
      win      <= '0;
      win_op   <= OP_POP;
      win_data <= '0;
      count    <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && |bus.req) begin
        ptr      <= arb_idx;
        win      <= arb_idx;
        win_op   <= bus.op[arb_idx];
        win_data <= bus.wdata[arb_idx*WIDTH +: WIDTH];
      end
      if (state == XFER) begin
        if (win_op == OP_PUSH) begin
          if (!full_c) count <= count + CW'(1);
        end else if (!empty_c) begin
          rdata_q <= mem[top_idx[AW-1:0]];
          count   <= top_idx;
        end else begin
          rdata_q <= '0;
        end
      end
    end
  end

  // NOTE: storage array has no reset; its contents are only read below count, so stale data is harmless.
  always_ff @(posedge clk) begin
    if (push_ok) mem[count[AW-1:0]] <= win_data;
  end

  // Outputs
  always_comb begin
    bus.gnt    = '0;
    bus.rvalid = 1'b0;
    err_pulse  = 1'b0;
    if (state == XFER) begin
      bus.gnt   = NREQ'(1) << win;
      err_pulse = op_err;
    end
    if (state == RESP) bus.rvalid = 1'b1;
  end

`ifdef LIFO_ERR_STICKY_EN
  logic err_hold;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       err_hold <= 1'b0;
    else if (err_pulse) err_hold <= 1'b1;
  end
  assign bus.err = err_pulse | err_hold;
`else
  assign bus.err = err_pulse;
`endif

  assign bus.rdata = rdata_q;
  assign bus.rid   = win;
  assign bus.count = count;
  assign bus.full  = full_c;
  assign bus.empty = empty_c;
endmodule

// File: tb/tb_lifo_share_ctrl.sv
// tb_lifo_share_ctrl: scoreboard bench for lifo_share_ctrl. The driver computes
// expected grants/responses from a stack model and round-robin order when it
// issues requests; the monitor compares whenever gnt or rvalid appears.
module tb_lifo_share_ctrl;
  import lifo_share_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
`ifdef LIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lifo_share_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  lifo_share_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: stack of pushed values plus round-robin last winner.
  typedef struct { int idx; bit op; bit err; } gexp_t;
  typedef struct { logic [WIDTH-1:0] data; int rid; } rexp_t;

  logic [WIDTH-1:0] stk[$];
  gexp_t gq[$];
  rexp_t rq[$];
  int    last_win   = NREQ - 1;
  bit    expect_rv  = 1'b0;
  bit    seen_err   = 1'b0;

  function automatic void model_op(input int i, input bit op, input logic [WIDTH-1:0] d);
    gexp_t g;
    rexp_t r;
    g.idx = i;
    g.op  = op;
    g.err = 1'b0;
    if (op == OP_PUSH) begin
      if (stk.size() >= DEPTH) g.err = 1'b1;
      else                     stk.push_back(d);
    end else begin
      r.rid = i;
      if (stk.size() == 0) begin
        g.err  = 1'b1;
        r.data = '0;
      end else begin
        r.data = stk.pop_back();
      end
      rq.push_back(r);
    end
    gq.push_back(g);
    last_win = i;
  endfunction

  // Monitor
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (!reset_n) begin
      expect_rv = 1'b0;
      seen_err  = 1'b0;
    end else begin
      check("rvalid_timing", bus.rvalid, expect_rv);
      expect_rv = 1'b0;
      if (bus.rvalid) begin
        if (rq.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          check("rdata", bus.rdata, r.data);
          check("rid", bus.rid, r.rid);
        end
      end
      if (bus.gnt != '0) begin
        check("gnt_onehot", $countones(bus.gnt), 1);
        if (gq.size() == 0) check("gnt_unexpected", bus.gnt, 0);
        else begin
          g = gq.pop_front();
          check("gnt_idx", bus.gnt, 32'(1) << g.idx);
          check("err_xfer", bus.err, g.err | (STICKY & seen_err));
          if (g.err) seen_err = 1'b1;
          expect_rv = (g.op == OP_POP);
        end
      end else begin
        check("err_quiet", bus.err, STICKY & seen_err);
      end
    end
  end

  // Issue a set of simultaneous requests and hold each until granted.
  task automatic run(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] ops,
                     input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1, input bit chk_lat);
    logic [NREQ-1:0] pend;
    int cur;
    int guard;
    pend = mask;
    cur  = last_win;
    while (pend != '0) begin
      cur = (cur + 1) % NREQ;
      if (((pend >> cur) & NREQ'(1)) != '0) begin
        model_op(cur, ((ops >> cur) & NREQ'(1)) != '0, (cur == 0) ? d0 : d1);
        pend = pend & ~(NREQ'(1) << cur);
      end
    end
    bus.op    = ops;
    bus.wdata = {d1, d0};
    bus.req   = mask;
    pend  = mask;
    guard = 0;
    while (pend != '0 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (chk_lat && guard == 1) check("req_to_gnt_latency", bus.gnt, mask);
      pend    = pend & ~bus.gnt;
      bus.req = pend;
    end
    if (pend != '0) check("grant_timeout", pend, 0);
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic status(input string tag);
    check({tag, "_count"}, bus.count, stk.size());
    check({tag, "_empty"}, bus.empty, stk.size() == 0);
    check({tag, "_full"},  bus.full,  stk.size() == DEPTH);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = '0;
    gq.delete();
    rq.delete();
    stk.delete();
    last_win = NREQ - 1;
    @(negedge clk);
    check("rst_gnt",    bus.gnt, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata",  bus.rdata, 0);
    check("rst_rid",    bus.rid, 0);
    check("rst_err",    bus.err, 0);
    check("rst_count",  bus.count, 0);
    check("rst_empty",  bus.empty, 1);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [NREQ-1:0] m;
    int guard;
    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;
    do_reset();

    // Requester 0 pushes three values, then requester 1 pops them back.
    run(2'b01, 2'b01, 8'h08, 8'h00, 1'b1);
    run(2'b01, 2'b01, 8'h11, 8'h00, 1'b1);
    run(2'b01, 2'b01, 8'h22, 8'h00, 1'b1);
    status("after_3_push");
    repeat (3) run(2'b10, 2'b00, 8'h00, 8'h00, 1'b1);
    status("after_3_pop");

    // Both requesters pushing at once: grants alternate.
    run(2'b11, 2'b11, 8'hA0, 8'hB0, 1'b0);
    run(2'b11, 2'b11, 8'hA1, 8'hB1, 1'b0);
    status("after_contend");

    // Overfill: ninth push errors, top stays 0x08.
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) run(2'b01, 2'b01, WIDTH'(i), 8'h00, 1'b1);
    status("after_overfill");
    run(2'b10, 2'b00, 8'h00, 8'h00, 1'b1);

    // Pop on empty.
    do_reset();
    run(2'b01, 2'b00, 8'h00, 8'h00, 1'b1);
    status("after_empty_pop");

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      m = NREQ'($urandom_range(1, 3));
      run(m, NREQ'($urandom), WIDTH'($urandom), WIDTH'($urandom), m != 2'b11);
      if (n % 10 == 9) status("random");
    end

    // Reset while a pop response is pending.
    do_reset();
    run(2'b01, 2'b01, 8'h5A, 8'h00, 1'b1);
    model_op(1, OP_POP, 8'h00);
    bus.op  = 2'b00;
    bus.req = 2'b10;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bus.gnt == '0 && guard < 20);
    check("resp_reset_gnt_seen", bus.gnt, 2'b10);
    bus.req = '0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("resp_reset_rvalid", bus.rvalid, 0);
    do_reset();
    status("after_resp_reset");
    run(2'b01, 2'b01, 8'h77, 8'h00, 1'b1);
    status("post_reset_push");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
